mem_ram_bist: RTL
=================

// Module: mem_ram_bist
// PURPOSE
//   Initiator/tester for the 32x8 synchronous memRAM (ports Clock, D, Address, WE, Q).
//   On Start, performs two march passes, each writing every word then reading it back
//   and comparing. Pass 0 writes data = SEED+addr; pass 1 writes the bitwise inverse.
//   Reports Done, Pass, an error count and the first failing location. Sits between
//   board controls (KEY/SW) and memRAM, replacing hand-driven stimulus.
// PARAMETERS
//   ADDR_W  5   RAM address width; DEPTH = 2**ADDR_W words
//   DATA_W  8   RAM data width
//   SEED    0   pattern offset, DATA_W bits
//   RD_LAT  1   cycles from Address to valid Q; legal values 1 or 2
// PORTS
//   Clock       in   1         single clock; all state changes on posedge
//   Reset       in   1         synchronous, active-high
//   Start       in   1         level, sampled each edge; begins a run from IDLE or DONE
//   Busy        out  1         run in progress
//   Done        out  1         run complete; held until next Start or Reset
//   Pass        out  1         valid while Done=1; 1 iff ErrCount==0
//   ErrCount    out  ADDR_W+2  mismatches this run, saturating at all-ones
//   FailAddr    out  ADDR_W    address of the first mismatch
//   FailData    out  DATA_W    Q value read at the first mismatch
//   RamD        out  DATA_W    to memRAM D
//   RamAddress  out  ADDR_W    to memRAM Address
//   RamWE       out  1         to memRAM WE
//   RamQ        in   DATA_W    from memRAM Q
// BEHAVIOUR
//   - All outputs are registered. On Reset every output is 0 and the FSM enters IDLE;
//     this includes a reset mid-run, with RamWE=0 from the next edge and no further writes.
//   - States: IDLE -> WRITE -> READ -> DRAIN -> (pass0: WRITE of pass1 | pass1: DONE).
//     DONE -> WRITE on Start. Start is ignored while Busy=1.
//   - Start edge: ErrCount, FailAddr, FailData, Done and Pass clear; Busy=1;
//     drive RamAddress=0.
//   - WRITE: RamWE=1 and RamD=pattern(pass,addr) for addr 0..DEPTH-1, one word per cycle.
//     Address counter wraps DEPTH-1 -> 0 into READ with no idle cycle.
//   - READ: RamWE=0 and addr 0..DEPTH-1 issued one per cycle. Expected value and address
//     pass through an RD_LAT-deep delay line. RamQ is compared with the delayed expected
//     value RD_LAT cycles after issue.
//   - DRAIN: RD_LAT cycles, no new address issued, and the last compares retire.
//   - Mismatch: ErrCount += 1, saturating. The first mismatch only loads FailAddr and
//     FailData; later mismatches do not overwrite them.
//   - pattern(p,a) = (SEED + a) mod 2**DATA_W when p=0; its bitwise inverse when p=1.
//     The address is zero-extended, or truncated if ADDR_W > DATA_W.
//   - Latency: Done=1 and Busy=0 exactly 2*(2*DEPTH+RD_LAT)+1 edges after the edge that
//     samples Start, which is 131 for the defaults. Pass is valid in the same cycle.
//   - Start held high continuously restarts immediately after DONE; Done pulses for 1 cycle.
// STRUCTURE
//   - Package mem_ram_bist_pkg holds the state enum (IDLE, WRITE, READ, DRAIN, DONE),
//     the pattern() function and the default widths.
//   - Sub-module mem_bist_cmp: the RD_LAT delay line for expected data and address,
//     plus the compare, ErrCount and first-fail capture logic.
//   - The top level holds the FSM, the address counter and the pass bit.
// TESTING
//   (Bench uses a behavioural memRAM with registered Q, RD_LAT=1, Clock period 2.)
//   1. Fault-free RAM, Start pulse -> Done at edge 131, Pass=1, ErrCount=0;
//      addr 7 holds 0xF8 at the end.
//   2. Q bit 3 stuck-at-1 at addr 5 -> ErrCount=1, FailAddr=5, FailData=0x0D, Pass=0.
//   3. Start re-pulsed at edge 40 of a run -> ignored; Done still at edge 131.
//   4. Reset at edge 50 (READ of pass 0) -> next cycle all outputs 0, RamWE=0;
//      a new Start completes after 131 edges.
//   5. RD_LAT=2, SEED=0x10, fault-free -> Done at edge 133, Pass=1.
//   6. Every word of pass 0 miscompares -> FailAddr=0, ErrCount=32; pass 1 clean -> Pass=0.

Source files
------------

// File: rtl/mem_ram_bist_pkg.sv
// rtl/mem_ram_bist_pkg.sv - shared state encoding, widths and test pattern for the RAM march tester
package mem_ram_bist_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam int PAT_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Callers truncate the result to their data width, which gives the mod 2**DATA_W wrap.
    function automatic logic [PAT_W-1:0] pattern(input logic p, input logic [PAT_W-1:0] seed,
                                                 input logic [PAT_W-1:0] addr);
        logic [PAT_W-1:0] v;
        v = seed + addr;
        return p ? ~v : v;
    endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// rtl/mem_bist_cmp.sv - read-latency delay line, data compare, error count and first-fail capture
module mem_bist_cmp
    import mem_ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [DATA_W-1:0] iss_exp,
    input  logic [DATA_W-1:0] q,
    output logic              mismatch,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    logic [RD_LAT-1:0] vld;
    logic [ADDR_W-1:0] addr_d [RD_LAT];
    logic [DATA_W-1:0] exp_d  [RD_LAT];

    assign mismatch = vld[RD_LAT-1] && (q != exp_d[RD_LAT-1]);

    always_ff @(posedge clk) begin
        addr_d[0] <= iss_addr;
        exp_d[0]  <= iss_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_d[i] <= addr_d[i-1];
            exp_d[i]  <= exp_d[i-1];
        end
        if (rst || clr) begin
            vld <= '0;
        end else begin
            vld[0] <= iss_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // A zero count means no mismatch yet this run, so it doubles as the first-fail flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch) begin
            if (err_count == '0) begin
                fail_addr <= addr_d[RD_LAT-1];
                fail_data <= q;
            end
            if (!(&err_count)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_ram_bist.sv
// rtl/mem_ram_bist.sv - two-pass write/read march tester driving a synchronous single-port RAM
module mem_ram_bist
    import mem_ram_bist_pkg::*;
#(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SEED   = '0,
    parameter int                RD_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [ADDR_W+1:0] ErrCount,
    output logic [ADDR_W-1:0] FailAddr,
    output logic [DATA_W-1:0] FailData,
    output logic [DATA_W-1:0] RamD,
    output logic [ADDR_W-1:0] RamAddress,
    output logic              RamWE,
    input  logic [DATA_W-1:0] RamQ
);

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [1:0]        drn, drn_n;
    logic              pass_q, pass_n;
    logic              busy_n, done_n, pass_out_n, we_n, iss, iss_n, clr;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_d_n, exp_q, exp_n, cur_pat;
    logic              mismatch;

    assign cur_pat = DATA_W'(pattern(pass_q, PAT_W'(SEED), PAT_W'(addr)));

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        drn_n      = drn;
        pass_n     = pass_q;
        busy_n     = Busy;
        done_n     = Done;
        pass_out_n = Pass;
        we_n       = 1'b0;
        iss_n      = 1'b0;
        ram_addr_n = RamAddress;
        ram_d_n    = RamD;
        exp_n      = exp_q;
        clr        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                // Busy is still high on the first DONE cycle; that cycle publishes the result.
                if (state == ST_DONE && Busy) begin
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                    pass_out_n = (ErrCount == '0) && !mismatch;
                end else if (Start) begin
                    clr        = 1'b1;
                    state_n    = ST_WRITE;
                    addr_n     = '0;
                    pass_n     = 1'b0;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_out_n = 1'b0;
                    ram_addr_n = '0;
                end
            end
            ST_WRITE: begin
                we_n       = 1'b1;
                ram_addr_n = addr;
                ram_d_n    = cur_pat;
                addr_n     = addr + 1'b1;
                if (&addr) begin
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                iss_n      = 1'b1;
                ram_addr_n = addr;
                exp_n      = cur_pat;
                addr_n     = addr + 1'b1;
                drn_n      = '0;
                if (&addr) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drn_n = drn + 1'b1;
                if (drn == DRAIN_LAST) begin
                    if (pass_q) begin
                        state_n = ST_DONE;
                    end else begin
                        pass_n  = 1'b1;
                        state_n = ST_WRITE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            addr       <= '0;
            drn        <= '0;
            pass_q     <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Pass       <= 1'b0;
            RamWE      <= 1'b0;
            RamAddress <= '0;
            RamD       <= '0;
            iss        <= 1'b0;
            exp_q      <= '0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            drn        <= drn_n;
            pass_q     <= pass_n;
            Busy       <= busy_n;
            Done       <= done_n;
            Pass       <= pass_out_n;
            RamWE      <= we_n;
            RamAddress <= ram_addr_n;
            RamD       <= ram_d_n;
            iss        <= iss_n;
            exp_q      <= exp_n;
        end
    end

    mem_bist_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) u_cmp (
        .clk      (Clock),
        .rst      (Reset),
        .clr      (clr),
        .iss_valid(iss),
        .iss_addr (RamAddress),
        .iss_exp  (exp_q),
        .q        (RamQ),
        .mismatch (mismatch),
        .err_count(ErrCount),
        .fail_addr(FailAddr),
        .fail_data(FailData)
    );

endmodule
